// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register-file writeback stage.
package wb_pkg;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    SRC_LD   = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_BASE = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Source-side bus of the writeback stage: ALU, base and load request/response channels.
interface reg_writeback_if;

  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        base_valid;
  logic [3:0]  base_addr;
  logic [31:0] base_data;
  logic        ld_req_valid;
  logic [3:0]  ld_req_addr;
  logic        ld_req_ready;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output base_valid, base_addr, base_data,
    output ld_req_valid, ld_req_addr,
    output ld_rsp_valid, ld_rsp_data,
    input  ld_req_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  base_valid, base_addr, base_data,
    input  ld_req_valid, ld_req_addr,
    input  ld_rsp_valid, ld_rsp_data,
    output ld_req_ready
  );

endinterface

// File: rtl/reg_writeback_ld_tag_fifo.sv
// Circular FIFO of destination tags for loads awaiting their in-order data return.
module ld_tag_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [3:0]       push_tag,
  input  logic             pop,
  output logic [3:0]       head,
  output logic [CNT_W-1:0] count
);

  logic [3:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && (count_r != CNT_W'(DEPTH));
  assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 4'd0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_tag;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Sole writer of the 16-entry register file: arbitrates ALU, base and load results
// onto three registered write ports plus the PC-load path, and tracks busy registers.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4,
  parameter int PC_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_writeback_if.slave    src,
  output logic              w_en1,
  output logic [3:0]        w_addr1,
  output logic [31:0]       w_data1,
  output logic              w_en2,
  output logic [3:0]        w_addr2,
  output logic [31:0]       w_data2,
  output logic              w_en3,
  output logic [3:0]        w_addr3,
  output logic [31:0]       w_data3,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_data,
  output logic [15:0]       busy,
  output logic              wb_err
);

  localparam int CNT_W = $clog2(LD_DEPTH) + 1;

  logic [CNT_W-1:0] fifo_count_s;
  logic [3:0]       fifo_head_s;
  logic             ld_accept_s;
  logic             ld_fire_s;
  logic             rsp_empty_s;
  wb_req_t          ld_wr_s;
  wb_req_t          alu_wr_s;
  wb_req_t          base_wr_s;
  logic             en1_s;
  logic             en2_s;
  logic             en3_s;
  logic             pc_hit_s;
  wb_src_e          pc_src_s;
  logic [PC_W-1:0]  pc_next_s;
  logic             err_s;
  logic [15:0]      busy_set_s;
  logic [15:0]      busy_clr_s;
  logic             ld_done_r;
  logic [3:0]       ld_done_addr_r;

  // Registered busy is used so a bit clearing this cycle cannot admit a new request.
  assign src.ld_req_ready = (fifo_count_s < CNT_W'(LD_DEPTH)) && !busy[src.ld_req_addr];
  assign ld_accept_s      = src.ld_req_valid && src.ld_req_ready;
  assign ld_fire_s        = src.ld_rsp_valid && (fifo_count_s != {CNT_W{1'b0}});
  assign rsp_empty_s      = src.ld_rsp_valid && (fifo_count_s == {CNT_W{1'b0}});

  ld_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ld_accept_s),
    .push_tag (src.ld_req_addr),
    .pop      (ld_fire_s),
    .head     (fifo_head_s),
    .count    (fifo_count_s)
  );

  assign ld_wr_s   = '{addr: fifo_head_s,   data: src.ld_rsp_data};
  assign alu_wr_s  = '{addr: src.alu_addr,  data: src.alu_data};
  assign base_wr_s = '{addr: src.base_addr, data: src.base_data};

  // Port enables: R15 never uses a port; on a shared address load beats ALU beats base.
  assign en3_s = ld_fire_s && (ld_wr_s.addr != REG_PC);
  assign en1_s = src.alu_valid && (alu_wr_s.addr != REG_PC)
               && !(en3_s && (ld_wr_s.addr == alu_wr_s.addr));
  assign en2_s = src.base_valid && (base_wr_s.addr != REG_PC)
               && !(en3_s && (ld_wr_s.addr == base_wr_s.addr))
               && !(en1_s && (alu_wr_s.addr == base_wr_s.addr));

  // PC-load source selection among R15 writers.
  always_comb begin
    pc_hit_s = 1'b0;
    pc_src_s = SRC_BASE;
    if (ld_fire_s && (ld_wr_s.addr == REG_PC)) begin
      pc_hit_s = 1'b1;
      pc_src_s = SRC_LD;
    end else if (src.alu_valid && (alu_wr_s.addr == REG_PC)) begin
      pc_hit_s = 1'b1;
      pc_src_s = SRC_ALU;
    end else if (src.base_valid && (base_wr_s.addr == REG_PC)) begin
      pc_hit_s = 1'b1;
      pc_src_s = SRC_BASE;
    end else begin
      pc_hit_s = 1'b0;
      pc_src_s = SRC_BASE;
    end
  end

  // PC value mux for the selected source.
  always_comb begin
    pc_next_s = {PC_W{1'b0}};
    case (pc_src_s)
      SRC_LD:   pc_next_s = ld_wr_s.data[PC_W-1:0];
      SRC_ALU:  pc_next_s = alu_wr_s.data[PC_W-1:0];
      SRC_BASE: pc_next_s = base_wr_s.data[PC_W-1:0];
      default:  pc_next_s = {PC_W{1'b0}};
    endcase
  end

  assign err_s = rsp_empty_s
               || (src.alu_valid && busy[alu_wr_s.addr])
               || (src.base_valid && busy[base_wr_s.addr]);

  // Busy clears on the edge after the load's write cycle, so the file already holds the data.
  assign busy_clr_s = ld_done_r ? (16'd1 << ld_done_addr_r) : 16'd0;
  assign busy_set_s = ld_accept_s ? (16'd1 << src.ld_req_addr) : 16'd0;

  // Output registers, busy scoreboard and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en1          <= 1'b0;
      w_addr1        <= 4'd0;
      w_data1        <= 32'd0;
      w_en2          <= 1'b0;
      w_addr2        <= 4'd0;
      w_data2        <= 32'd0;
      w_en3          <= 1'b0;
      w_addr3        <= 4'd0;
      w_data3        <= 32'd0;
      pc_load        <= 1'b0;
      pc_data        <= {PC_W{1'b0}};
      busy           <= 16'd0;
      wb_err         <= 1'b0;
      ld_done_r      <= 1'b0;
      ld_done_addr_r <= 4'd0;
    end else begin
      w_en1 <= en1_s;
      w_en2 <= en2_s;
      w_en3 <= en3_s;
      if (en1_s) begin
        w_addr1 <= alu_wr_s.addr;
        w_data1 <= alu_wr_s.data;
      end
      if (en2_s) begin
        w_addr2 <= base_wr_s.addr;
        w_data2 <= base_wr_s.data;
      end
      if (en3_s) begin
        w_addr3 <= ld_wr_s.addr;
        w_data3 <= ld_wr_s.data;
      end
      pc_load <= pc_hit_s;
      if (pc_hit_s) begin
        pc_data <= pc_next_s;
      end
      busy           <= (busy & ~busy_clr_s) | busy_set_s;
      wb_err         <= wb_err | err_s;
      ld_done_r      <= ld_fire_s;
      ld_done_addr_r <= ld_wr_s.addr;
    end
  end

endmodule
